// File: rtl/band_power_8to14.sv
// Windowed mean-|y| band-power estimator with hysteresis detect for the 8-14 Hz channel.
// Latency: window mean appears one edge after its last sample is accepted; detect may move one edge later.
// Backpressure: none, one sample per clock is always accepted and windows run back-to-back.
//
// Ports:
//   clk, reset (async, active-low), clear (sync flush of window and hysteresis counts)
//   y_in/y_valid   signed filter sample stream
//   threshold      unsigned level compared against each window mean
//   power/power_valid  mean |y| of the last complete window, pulse on update
//   detect         band-activity flag with HOLD-window hysteresis
module band_power_8to14 #(
    parameter int WIDTH    = 32,
    parameter int WIN_LOG2 = 8,
    parameter int HOLD     = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic                    y_valid,
    input  logic        [WIDTH-1:0] threshold,
    output logic        [WIDTH-1:0] power,
    output logic                    power_valid,
    output logic                    detect
);

    localparam int ACC_W = WIDTH + WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;
    localparam logic [WIN_LOG2-1:0] CNT_ONE  = WIN_LOG2'(1);
    localparam logic [WIDTH-1:0]    Y_ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0]    Y_MIN    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]    Y_MAXPOS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [3:0]          HOLD_C   = 4'(HOLD);

    typedef enum logic {
        QUIET  = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // stage 1
    logic                s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    abs_y;
    // stage 2
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    acc_sum;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]    power_q, power_d;
    logic                power_valid_q, power_valid_d;
    // hysteresis
    logic [3:0]          up_cnt_q, up_cnt_d;
    logic [3:0]          dn_cnt_q, dn_cnt_d;
    logic                above;
    logic                eval;
    state_t              state_q, state_d;

    // Magnitude; the most negative value has no positive twin, so it clips.
    always_comb begin
        abs_y = y_in;
        if (y_in[WIDTH-1]) begin
            if (y_in == Y_MIN) begin
                abs_y = Y_MAXPOS;
            end else begin
                abs_y = ~y_in + Y_ONE;
            end
        end
    end

    always_comb begin
        s1_valid_d = y_valid & ~clear;
        // Hold the last magnitude when idle; it is only consumed with s1_valid.
        a_d        = y_valid ? abs_y : a_q;
    end

    // Sum of all 2^WIN_LOG2 magnitudes fits in ACC_W bits, so no guard bit is needed.
    assign acc_sum = acc_q + {{WIN_LOG2{1'b0}}, a_q};

    always_comb begin
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        power_d       = power_q;
        power_valid_d = 1'b0;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (s1_valid_q) begin
            if (cnt_q == CNT_LAST) begin
                power_d       = acc_sum[ACC_W-1:WIN_LOG2];
                power_valid_d = 1'b1;
                acc_d         = '0;
                cnt_d         = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // Hysteresis runs the cycle after a new mean lands, on the registered value.
    assign above = (power_q > threshold);
    assign eval  = power_valid_q & ~clear;

    always_comb begin
        up_cnt_d = up_cnt_q;
        dn_cnt_d = dn_cnt_q;
        if (clear) begin
            up_cnt_d = '0;
            dn_cnt_d = '0;
        end else if (power_valid_q) begin
            if (above) begin
                up_cnt_d = (up_cnt_q >= HOLD_C) ? HOLD_C : up_cnt_q + 4'd1;
                dn_cnt_d = '0;
            end else begin
                dn_cnt_d = (dn_cnt_q >= HOLD_C) ? HOLD_C : dn_cnt_q + 4'd1;
                up_cnt_d = '0;
            end
        end
    end

    // Detect FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            QUIET:  if (eval && above && (up_cnt_d == HOLD_C))   state_d = ACTIVE;
            ACTIVE: if (eval && !above && (dn_cnt_d == HOLD_C))  state_d = QUIET;
            default: state_d = QUIET;
        endcase
    end

    // Detect FSM: outputs
    always_comb begin
        detect = (state_q == ACTIVE);
    end

    assign power       = power_q;
    assign power_valid = power_valid_q;

    // Detect FSM state register plus datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q    <= 1'b0;
            a_q           <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            power_q       <= '0;
            power_valid_q <= 1'b0;
            up_cnt_q      <= '0;
            dn_cnt_q      <= '0;
            state_q       <= QUIET;
        end else begin
            s1_valid_q    <= s1_valid_d;
            a_q           <= a_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            power_q       <= power_d;
            power_valid_q <= power_valid_d;
            up_cnt_q      <= up_cnt_d;
            dn_cnt_q      <= dn_cnt_d;
            state_q       <= state_d;
        end
    end

endmodule

// File: tb/tb_band_power_8to14.sv
module tb_band_power_8to14;

    localparam int W  = 32;
    localparam int WL = 2;
    localparam int H  = 2;
    localparam int WN = 1 << WL;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               clear = 1'b0;
    logic signed [W-1:0] y_in = '0;
    logic               y_valid = 1'b0;
    logic [W-1:0]       threshold = 32'd100;
    logic [W-1:0]       power;
    logic               power_valid;
    logic               detect;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // reference model state: what the spec says the outputs should be
    longint m_win[$];
    bit     m_s1v;
    longint m_s1a;
    longint m_power;
    bit     m_pv;
    bit     m_det;
    int     m_up, m_dn;
    bit     o_pv, o_s1v;
    longint o_pow, o_s1a;

    band_power_8to14 #(.WIDTH(W), .WIN_LOG2(WL), .HOLD(H)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .y_in        (y_in),
        .y_valid     (y_valid),
        .threshold   (threshold),
        .power       (power),
        .power_valid (power_valid),
        .detect      (detect)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint mag(input logic signed [W-1:0] v);
        longint x;
        x = v;
        if (x < 0) x = -x;
        if (x > 64'sd2147483647) x = 64'sd2147483647;
        return x;
    endfunction

    task automatic model_reset();
        m_win.delete();
        m_s1v = 0; m_s1a = 0; m_power = 0; m_pv = 0; m_det = 0; m_up = 0; m_dn = 0;
    endtask

    // One rising edge of the specified behaviour.
    task automatic model_step();
        longint s;
        if (!reset) begin
            model_reset();
            return;
        end
        o_pv = m_pv; o_pow = m_power; o_s1v = m_s1v; o_s1a = m_s1a;
        if (clear) begin
            m_win.delete();
            m_s1v = 0; m_up = 0; m_dn = 0; m_pv = 0;
            return;
        end
        m_pv = 0;
        if (o_pv) begin
            if (o_pow > longint'(threshold)) begin
                m_up = (m_up + 1 > H) ? H : m_up + 1;
                m_dn = 0;
                if (m_up == H) m_det = 1;
            end else begin
                m_dn = (m_dn + 1 > H) ? H : m_dn + 1;
                m_up = 0;
                if (m_dn == H) m_det = 0;
            end
        end
        if (o_s1v) begin
            m_win.push_back(o_s1a);
            if (m_win.size() == WN) begin
                s = 0;
                foreach (m_win[i]) s += m_win[i];
                m_power = s / WN;
                m_pv = 1;
                m_win.delete();
            end
        end
        m_s1v = y_valid;
        m_s1a = mag(y_in);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("power", power, m_power);
        chk("power_valid", power_valid, m_pv);
        chk("detect", detect, m_det);
        if (power_valid === 1'b1) pulses++;
    endtask

    task automatic drive(input logic signed [W-1:0] v, input logic vld);
        y_in    = v;
        y_valid = vld;
        tick();
    endtask

    task automatic window(input logic signed [W-1:0] v);
        for (int i = 0; i < WN; i++) drive(v, 1'b1);
        for (int i = 0; i < 3; i++) drive(0, 1'b0);
    endtask

    int p0;
    logic signed [W-1:0] y_min;
    logic signed [W-1:0] basic [4];

    initial begin
        y_min = {1'b1, {(W-1){1'b0}}};
        basic[0] = 10; basic[1] = -20; basic[2] = 30; basic[3] = -40;
        model_reset();

        // reset held with live input
        for (int i = 0; i < 5; i++) begin
            drive($urandom, 1'b1);
            chk("rst_power", power, 0);
            chk("rst_pv", power_valid, 0);
            chk("rst_detect", detect, 0);
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) drive($urandom, 1'b0);
        chk("no_pulse_after_rst", pulses, 0);

        // basic window
        p0 = pulses;
        for (int i = 0; i < 4; i++) drive(basic[i], 1'b1);
        drive(0, 1'b0);
        chk("basic_power", power, 25);
        chk("basic_pv_edge", power_valid, 1);
        drive(0, 1'b0);
        chk("basic_pv_one_cycle", power_valid, 0);
        chk("basic_pulses", pulses - p0, 1);

        // saturation of most negative sample
        window(y_min);
        chk("sat_neg", power, 64'd2147483647);

        // gaps between samples
        p0 = pulses;
        for (int i = 0; i < 4; i++) begin
            drive(basic[i], 1'b1);
            if (i != 3) begin
                int g;
                g = $urandom_range(1, 3);
                for (int k = 0; k < g; k++) drive(0, 1'b0);
                chk("gap_no_pulse", pulses - p0, 0);
            end
        end
        for (int i = 0; i < 3; i++) drive(0, 1'b0);
        chk("gap_power", power, 25);
        chk("gap_pulses", pulses - p0, 1);

        window(32'sh7fffffff);
        chk("sat_pos", power, 64'd2147483647);

        // hysteresis, threshold 100
        threshold = 32'd100;
        clear = 1'b1; drive(0, 1'b0); clear = 1'b0;
        window(200);
        chk("hy_w1", detect, 0);
        for (int i = 0; i < WN; i++) drive(200, 1'b1);
        drive(0, 1'b0);
        chk("hy_pulse2", power_valid, 1);
        chk("hy_not_yet", detect, 0);
        drive(0, 1'b0);
        chk("hy_rise", detect, 1);
        drive(0, 1'b0);
        window(50);  chk("hy_50a", detect, 1);
        window(200); chk("hy_200", detect, 1);
        window(50);  chk("hy_50b", detect, 1);
        window(50);  chk("hy_fall", detect, 0);
        window(200); window(200); chk("hy_rise2", detect, 1);
        window(100); chk("hy_eq1", detect, 1);
        window(100); chk("hy_eq_below", detect, 0);

        // clear mid-window
        drive(1000, 1'b1); drive(1000, 1'b1);
        clear = 1'b1; drive(0, 1'b0); clear = 1'b0;
        window(8);
        chk("clear_power", power, 8);

        // reset mid-window
        threshold = 32'd0;
        window(300); window(300);
        chk("pre_rst_detect", detect, 1);
        drive(1000, 1'b1); drive(1000, 1'b1);
        reset = 1'b0; model_reset();
        #1;
        chk("async_rst_power", power, 0);
        chk("async_rst_detect", detect, 0);
        drive(0, 1'b0);
        reset = 1'b1;
        threshold = 32'd100;
        window(8);
        chk("rst_mid_power", power, 8);
        chk("rst_mid_detect", detect, 0);

        // clear with the last sample's acceptance edge
        p0 = pulses;
        for (int i = 0; i < WN - 1; i++) drive(8, 1'b1);
        clear = 1'b1; drive(500, 1'b1); clear = 1'b0;
        for (int i = 0; i < 3; i++) drive(0, 1'b0);
        chk("clear_last_a", pulses - p0, 0);
        // clear on the closing accumulate edge
        for (int i = 0; i < WN; i++) drive(8, 1'b1);
        clear = 1'b1; drive(0, 1'b0); clear = 1'b0;
        for (int i = 0; i < 3; i++) drive(0, 1'b0);
        chk("clear_last_b", pulses - p0, 0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) threshold = $urandom_range(0, 300);
            clear = ($urandom_range(0, 99) < 2);
            reset = ($urandom_range(0, 599) != 0);
            if (!reset) model_reset();
            if ($urandom_range(0, 99) == 0) y_in = y_min;
            else y_in = $urandom_range(0, 800) - 400;
            y_valid = ($urandom_range(0, 9) < 7);
            tick();
        end
        clear = 1'b0;
        reset = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
